// File: rtl/fifo_sync_ctrl.sv
// Control path for a single-clock FIFO driving an external dual-port RAM.
// Supports non-power-of-2 depth, threshold flags and sticky overflow/underflow reporting.
module fifo_sync_ctrl #(
    parameter int unsigned MEMORY_DEPTH = 6,
    parameter int unsigned ADDRESS_SIZE = 3,
    parameter int unsigned AF_LEVEL     = 5,
    parameter int unsigned AE_LEVEL     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic                    clr_err,
    output logic [ADDRESS_SIZE-1:0] w_ptr,
    output logic [ADDRESS_SIZE-1:0] r_ptr,
    output logic                    cw_en,
    output logic                    cr_en,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam logic [ADDRESS_SIZE-1:0] PTR_LAST = ADDRESS_SIZE'(MEMORY_DEPTH - 1);
    localparam logic [ADDRESS_SIZE-1:0] PTR_ONE  = ADDRESS_SIZE'(1);
    localparam logic [ADDRESS_SIZE:0]   CNT_FULL = (ADDRESS_SIZE + 1)'(MEMORY_DEPTH);
    localparam logic [ADDRESS_SIZE:0]   CNT_AF   = (ADDRESS_SIZE + 1)'(AF_LEVEL);
    localparam logic [ADDRESS_SIZE:0]   CNT_AE   = (ADDRESS_SIZE + 1)'(AE_LEVEL);
    localparam logic [ADDRESS_SIZE:0]   CNT_ONE  = (ADDRESS_SIZE + 1)'(1);

    logic [ADDRESS_SIZE-1:0] w_ptr_q, w_ptr_d;
    logic [ADDRESS_SIZE-1:0] r_ptr_q, r_ptr_d;
    logic [ADDRESS_SIZE:0]   count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    // Flags decode the registered count only, so they never glitch between edges.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);

    assign cw_en = w_en & ~full;
    assign cr_en = r_en & ~empty;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (cw_en) begin
            w_ptr_d = (w_ptr_q == PTR_LAST) ? '0 : w_ptr_q + PTR_ONE;
        end
        if (cr_en) begin
            r_ptr_d = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + PTR_ONE;
        end

        case ({cw_en, cr_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Clear first so a simultaneous set takes priority.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en && full) begin
            overflow_d = 1'b1;
        end
        if (r_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign w_ptr     = w_ptr_q;
    assign r_ptr     = r_ptr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scoreboard bench for fifo_sync_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_fifo_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_en;
    logic       r_en;
    logic       clr_err;
    logic [2:0] w_ptr;
    logic [2:0] r_ptr;
    logic       cw_en;
    logic       cr_en;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    fifo_sync_ctrl #(
        .MEMORY_DEPTH(6),
        .ADDRESS_SIZE(3),
        .AF_LEVEL    (5),
        .AE_LEVEL    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .r_en        (r_en),
        .clr_err     (clr_err),
        .w_ptr       (w_ptr),
        .r_ptr       (r_ptr),
        .cw_en       (cw_en),
        .cr_en       (cr_en),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cw;
        logic       cr;
        logic [2:0] wp;
        logic [2:0] rp;
        logic [3:0] cnt;
        logic [3:0] fl;   // {full, empty, almost_full, almost_empty}
        logic       ovf;
        logic       unf;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_idx = 0;

    // Hand-derived flag pattern {full, empty, af, ae} for count 0..6.
    logic [3:0] fl_tab [0:6];
    initial begin
        fl_tab[0] = 4'b0101;
        fl_tab[1] = 4'b0001;
        fl_tab[2] = 4'b0000;
        fl_tab[3] = 4'b0000;
        fl_tab[4] = 4'b0000;
        fl_tab[5] = 4'b0010;
        fl_tab[6] = 4'b1010;
    end

    task automatic chk(input string name, input int idx, input int unsigned act,
                       input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("cw_en", e.idx, cw_en, e.cw);
            chk("cr_en", e.idx, cr_en, e.cr);
            chk("w_ptr", e.idx, w_ptr, e.wp);
            chk("r_ptr", e.idx, r_ptr, e.rp);
            chk("count", e.idx, count, e.cnt);
            chk("flags", e.idx, {full, empty, almost_full, almost_empty}, e.fl);
            chk("overflow", e.idx, overflow, e.ovf);
            chk("underflow", e.idx, underflow, e.unf);
        end
    end

    // Drive one cycle's inputs after the edge and queue what the DUT must show this cycle.
    task automatic step(input logic rv, input logic w, input logic r, input logic c,
                        input logic ecw, input logic ecr, input int ewp, input int erp,
                        input int ecnt, input logic [3:0] efl, input logic eovf,
                        input logic eunf);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = rv;
        w_en    = w;
        r_en    = r;
        clr_err = c;
        e.cw  = ecw;
        e.cr  = ecr;
        e.wp  = 3'(ewp);
        e.rp  = 3'(erp);
        e.cnt = 4'(ecnt);
        e.fl  = efl;
        e.ovf = eovf;
        e.unf = eunf;
        e.idx = step_idx;
        step_idx++;
        sb.push_back(e);
    endtask

    initial begin
        rst     = 1'b1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;

        // 1. reset and idle
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 0, 0);

        // 2. fill to full, then a rejected write
        for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 1, 0, k, 0, k, fl_tab[k], 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 6, 4'b1010, 0, 0);

        // 3. simultaneous request on full: read wins; then clear overflow
        step(0, 1, 1, 0, 0, 1, 0, 0, 6, 4'b1010, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0, 1, 5, 4'b0010, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5, 4'b0010, 0, 0);

        // 4. reset, load 3, then 10 cycles of simultaneous read/write
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 1, 0, k, 0, k, fl_tab[k], 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 1, 1, (3 + i) % 6, i % 6, 3, 4'b0000, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 4, 3, 4'b0000, 0, 0);

        // 5. drain, read on empty, clear and set together
        for (int j = 0; j < 3; j++) step(0, 0, 1, 0, 0, 1, 1, (4 + j) % 6, 3 - j, fl_tab[3 - j], 0, 0);
        step(0, 0, 1, 0, 0, 0, 1, 1, 0, 4'b0101, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 1, 0, 4'b0101, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0101, 0, 1);

        // 6. burst to count 4, async reset mid-cycle, then resume
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1, 0, (1 + k) % 6, 1, k, fl_tab[k], 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0, 4'b0101, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0001, 0, 0);

        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
